alu_sequencer: RTL and testbench
================================

# alu_sequencer

Sequencing controller for the 4-bit ALU/seven-segment datapath on the lab board. Captures operand A, operand B and an opcode from the slide switches on successive presses of a "next" button, drives them onto the ALU inputs, and registers the ALU result and flags. Also chooses what the two seven-segment displays show in each phase. Sits between the board I/O (switches, buttons) and the ALU instance.

## Interface
- N, 4, operand/result width
- OPW, 4, opcode width (OPW ≤ N)
- TIMEOUT_CYCLES, 50_000_000, idle cycles before auto-return (used only with the timeout feature)

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- sw  in  N  switch value (operand or opcode source)
- btn_next  in  1  raw "next" button level, asynchronous to clk
- btn_clear  in  1  raw "clear" button level, asynchronous to clk
- alu_a  out  N  operand A to ALU
- alu_b  out  N  operand B to ALU
- alu_op  out  OPW  opcode to ALU
- alu_result  in  N  combinational ALU result
- alu_flags  in  4  combinational ALU flags {N,Z,C,V}
- result_q  out  N  registered result
- flags_q  out  4  registered flags
- disp_left  out  N  value for left display
- disp_right  out  N  value for right display
- state_o  out  3  current state encoding (LED debug)
- done  out  1  high while a valid result is held

## Operation
- Each button goes through a 2-flop synchronizer plus a previous-value flop. A single-cycle press pulse fires on the synchronized rising edge. Holding the button gives exactly one pulse.
- States and encoding: S_A=0, S_B=1, S_OP=2, S_EXEC=3, S_SHOW=4. Encodings 5–7 go to S_A on the next edge.
- S_A: on next pulse, alu_a←sw, go to S_B.
- S_B: on next pulse, alu_b←sw, go to S_OP.
- S_OP: on next pulse, alu_op←sw[OPW-1:0], go to S_EXEC.
- S_EXEC: lasts exactly one cycle. result_q←alu_result, flags_q←alu_flags, done←1, go to S_SHOW.
- S_SHOW: on next pulse, done←0, go to S_A. alu_a, alu_b and alu_op keep their values.
- Clear pulse in any state: go to S_A and zero alu_a, alu_b, alu_op, result_q, flags_q and done. Clear has priority over a simultaneous next pulse.
- A next pulse in S_EXEC is ignored.
- Display mux (combinational from state and registers):
  - S_A: left=sw, right=0
  - S_B: left=alu_a, right=sw
  - S_OP: left=alu_a, right=alu_b
  - S_EXEC: left=alu_a, right=alu_b
  - S_SHOW: left=result_q, right=flags_q zero-extended/truncated to N
- No arithmetic is done in this block. Widths pass through unchanged.

## Timing
- Reset: state S_A. All registered outputs 0: alu_a, alu_b, alu_op, result_q, flags_q, done. state_o=0. disp_left=sw, disp_right=0.
- Press latency:
  - btn first sampled high at edge k → pulse during cycle after edge k+2.
  - State and register update at edge k+3.
- S_EXEC → S_SHOW: one cycle. The result is sampled at the edge that leaves S_EXEC.
- rst asserted mid-sequence: immediate asynchronous return to reset values, including synchronizer flops.
- Button released and re-pressed with fewer than 3 synchronized low cycles may merge into one pulse. This is acceptable.

## Configuration
- ALU_SEQ_TIMEOUT_EN defined:
  - An idle counter runs in S_B, S_OP and S_SHOW.
  - It clears on any press pulse or state change.
  - When it reaches TIMEOUT_CYCLES−1, the block does the clear action and goes to S_A.
- Undefined: no counter is built, and the block waits indefinitely in every state.

## Test plan
- Reset, then sw=3 next, sw=5 next, sw=op_ADD next, ALU model returns 8 → result_q=8, done=1 in S_SHOW, disp_left=8, flags on disp_right.
- btn_next held high 100 cycles in S_A with sw=9 → exactly one transition to S_B, alu_a=9, press effective 3 edges after first high sample.
- btn_clear and btn_next rising the same cycle in S_OP → state S_A, all operand/result registers 0, done=0.
- rst asserted asynchronously while in S_EXEC → outputs 0 immediately without a clock edge, state_o=0.
- Two full sequences back-to-back (2+2, then 15+1): second result_q reflects new operands, done drops on the next press in S_SHOW.
- With ALU_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16: idle in S_B for 16 cycles → S_A with alu_a=0. Without the macro: still in S_B after 1000 cycles.

Source files
------------

// File: rtl/alu_sequencer.sv
// Steps operand A, operand B and opcode capture from switches on "next" presses, registers the ALU result and muxes the displays.
// Optional idle auto-return to S_A is built only when ALU_SEQ_TIMEOUT_EN is defined.
module alu_sequencer #(
  parameter int N              = 4,
  parameter int OPW            = 4,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   sw,
  input  logic           btn_next,
  input  logic           btn_clear,
  output logic [N-1:0]   alu_a,
  output logic [N-1:0]   alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic [N-1:0]   alu_result,
  input  logic [3:0]     alu_flags,
  output logic [N-1:0]   result_q,
  output logic [3:0]     flags_q,
  output logic [N-1:0]   disp_left,
  output logic [N-1:0]   disp_right,
  output logic [2:0]     state_o,
  output logic           done
);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic next_s1, next_s2, next_prev, next_pulse;
  logic clr_s1, clr_s2, clr_prev, clear_pulse;
  logic timeout;
  logic do_clear;

  // Pulse is registered so a press lands three edges after the first high sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_s1     <= 1'b0;
      next_s2     <= 1'b0;
      next_prev   <= 1'b0;
      next_pulse  <= 1'b0;
      clr_s1      <= 1'b0;
      clr_s2      <= 1'b0;
      clr_prev    <= 1'b0;
      clear_pulse <= 1'b0;
    end else begin
      next_s1     <= btn_next;
      next_s2     <= next_s1;
      next_prev   <= next_s2;
      next_pulse  <= next_s2 & ~next_prev;
      clr_s1      <= btn_clear;
      clr_s2      <= clr_s1;
      clr_prev    <= clr_s2;
      clear_pulse <= clr_s2 & ~clr_prev;
    end
  end

`ifdef ALU_SEQ_TIMEOUT_EN
  logic [31:0] idle_cnt;
  logic        idle_state;

  assign idle_state = (state == S_B) || (state == S_OP) || (state == S_SHOW);
  assign timeout    = idle_state && (idle_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (!idle_state || next_pulse || clear_pulse || (state_nxt != state)) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 32'd1;
    end
  end
`else
  logic timeout_unused;
  assign timeout        = 1'b0;
  assign timeout_unused = (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    state_nxt = state;
    do_clear  = clear_pulse | timeout;
    case (state)
      S_A:     if (next_pulse) state_nxt = S_B;
      S_B:     if (next_pulse) state_nxt = S_OP;
      S_OP:    if (next_pulse) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_SHOW;
      S_SHOW:  if (next_pulse) state_nxt = S_A;
      default: state_nxt = S_A;
    endcase
    if (do_clear) state_nxt = S_A;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_A;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      result_q <= '0;
      flags_q  <= '0;
      done     <= 1'b0;
    end else if (do_clear) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      result_q <= '0;
      flags_q  <= '0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_A:    if (next_pulse) alu_a <= sw;
        S_B:    if (next_pulse) alu_b <= sw;
        S_OP:   if (next_pulse) alu_op <= sw[OPW-1:0];
        S_EXEC: begin
          result_q <= alu_result;
          flags_q  <= alu_flags;
          done     <= 1'b1;
        end
        S_SHOW: if (next_pulse) done <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    disp_left  = sw;
    disp_right = '0;
    case (state)
      S_A: begin
        disp_left  = sw;
        disp_right = '0;
      end
      S_B: begin
        disp_left  = alu_a;
        disp_right = sw;
      end
      S_OP, S_EXEC: begin
        disp_left  = alu_a;
        disp_right = alu_b;
      end
      S_SHOW: begin
        disp_left  = result_q;
        disp_right = N'(flags_q);
      end
      default: ;
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboarded bench for alu_sequencer with a small behavioural ALU on the datapath side.
module tb_alu_sequencer;

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int TB_TIMEOUT = 16;
`else
  localparam int TB_TIMEOUT = 50_000_000;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] sw = '0;
  logic       btn_next = 1'b0;
  logic       btn_clear = 1'b0;
  logic [3:0] alu_a, alu_b, alu_op;
  logic [3:0] alu_result, alu_flags;
  logic [3:0] result_q, flags_q, disp_left, disp_right;
  logic [2:0] state_o;
  logic       done;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  alu_sequencer #(.N(4), .OPW(4), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn_next(btn_next), .btn_clear(btn_clear),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .result_q(result_q), .flags_q(flags_q),
    .disp_left(disp_left), .disp_right(disp_right),
    .state_o(state_o), .done(done)
  );

  always #5 clk = ~clk;

  // ALU stand-in: op 0 = ADD, op 2 = XOR, otherwise AND; flags {N,Z,C,V}
  logic [4:0] sum5;
  logic       c_f, v_f;
  always_comb begin
    sum5       = {1'b0, alu_a} + {1'b0, alu_b};
    c_f        = 1'b0;
    v_f        = 1'b0;
    alu_result = alu_a & alu_b;
    case (alu_op)
      4'd0: begin
        alu_result = sum5[3:0];
        c_f        = sum5[4];
        v_f        = (alu_a[3] == alu_b[3]) && (sum5[3] != alu_a[3]);
      end
      4'd2:    alu_result = alu_a ^ alu_b;
      default: alu_result = alu_a & alu_b;
    endcase
    alu_flags = {alu_result[3], (alu_result == 4'd0), c_f, v_f};
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_next(input logic [3:0] v);
    sw = v;
    btn_next = 1'b1;
    tick(5);
    btn_next = 1'b0;
    tick(5);
  endtask

  task automatic run_sequence(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                              input logic [3:0] res, input logic [3:0] flg);
    press_next(a);
    press_next(b);
    exp_q.push_back({res, flg});
    press_next(op);
  endtask

  task automatic test_reset;
    sw = 4'd7;
    rst = 1'b1;
    tick(2);
    tests++;
    if (state_o !== 3'd0 || alu_a !== 4'd0 || alu_b !== 4'd0 || alu_op !== 4'd0 ||
        result_q !== 4'd0 || flags_q !== 4'd0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_regs got st=%0d a=%0d b=%0d op=%0d r=%0d f=%0d d=%0d want all 0",
               state_o, alu_a, alu_b, alu_op, result_q, flags_q, done);
    end
    tests++;
    if (disp_left !== 4'd7 || disp_right !== 4'd0) begin
      fails++;
      $display("FAIL reset_disp got L=%0d R=%0d want L=7 R=0", disp_left, disp_right);
    end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_basic;
    logic [7:0] e;
    press_next(4'd3);
    sw = 4'd5;
    #1;
    tests++;
    if (state_o !== 3'd1 || disp_left !== 4'd3 || disp_right !== 4'd5) begin
      fails++;
      $display("FAIL basic_sb got st=%0d L=%0d R=%0d want st=1 L=3 R=5", state_o, disp_left, disp_right);
    end
    press_next(4'd5);
    tests++;
    if (state_o !== 3'd2 || disp_left !== 4'd3 || disp_right !== 4'd5) begin
      fails++;
      $display("FAIL basic_sop got st=%0d L=%0d R=%0d want st=2 L=3 R=5", state_o, disp_left, disp_right);
    end
    exp_q.push_back({4'd8, 4'b1001});
    press_next(4'd0);
    e = exp_q.pop_front();
    tests++;
    if (state_o !== 3'd4 || done !== 1'b1) begin
      fails++;
      $display("FAIL basic_show got st=%0d done=%0d want st=4 done=1", state_o, done);
    end
    tests++;
    if (result_q !== e[7:4] || flags_q !== e[3:0] || disp_left !== e[7:4] || disp_right !== e[3:0]) begin
      fails++;
      $display("FAIL basic_result got r=%0d f=%b L=%0d R=%b want r=%0d f=%b",
               result_q, flags_q, disp_left, disp_right, e[7:4], e[3:0]);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] ta[3] = '{4'd2, 4'd15, 4'd6};
    logic [3:0] tb_[3] = '{4'd2, 4'd1, 4'd3};
    logic [3:0] top[3] = '{4'd0, 4'd0, 4'd2};
    logic [3:0] tr[3] = '{4'd4, 4'd0, 4'd5};
    logic [3:0] tf[3] = '{4'b0000, 4'b0110, 4'b0000};
    logic [7:0] e;
    int n;
    press_next(4'd0);
    for (int i = 0; i < 3; i++) begin
      run_sequence(ta[i], tb_[i], top[i], tr[i], tf[i]);
      n = 0;
      while (state_o !== 3'd4 && n < 20) begin
        tick(1);
        n++;
      end
      e = exp_q.pop_front();
      tests++;
      if (state_o !== 3'd4 || done !== 1'b1 || result_q !== e[7:4] || flags_q !== e[3:0]) begin
        fails++;
        $display("FAIL b2b_result[%0d] got st=%0d d=%0d r=%0d f=%b want st=4 d=1 r=%0d f=%b",
                 i, state_o, done, result_q, flags_q, e[7:4], e[3:0]);
      end
      if (i < 2) begin
        press_next(4'd0);
        tests++;
        if (done !== 1'b0 || state_o !== 3'd0 || result_q !== e[7:4]) begin
          fails++;
          $display("FAIL b2b_leave[%0d] got d=%0d st=%0d r=%0d want d=0 st=0 r=%0d",
                   i, done, state_o, result_q, e[7:4]);
        end
      end
    end
  endtask

  task automatic test_hold_latency;
    int hold;
`ifdef ALU_SEQ_TIMEOUT_EN
    hold = 8;
`else
    hold = 96;
`endif
    press_next(4'd0);
    sw = 4'd9;
    btn_next = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      tests++;
      if (state_o !== 3'd0) begin
        fails++;
        $display("FAIL hold_early[%0d] got st=%0d want 0", k, state_o);
      end
    end
    tick(1);
    tests++;
    if (state_o !== 3'd1 || alu_a !== 4'd9) begin
      fails++;
      $display("FAIL hold_edge3 got st=%0d a=%0d want st=1 a=9", state_o, alu_a);
    end
    tick(hold);
    tests++;
    if (state_o !== 3'd1) begin
      fails++;
      $display("FAIL hold_single got st=%0d want 1", state_o);
    end
    btn_next = 1'b0;
    tick(5);
  endtask

  task automatic test_clear;
    press_next(4'd4);
    btn_next = 1'b1;
    btn_clear = 1'b1;
    tick(6);
    btn_next = 1'b0;
    btn_clear = 1'b0;
    tick(4);
    tests++;
    if (state_o !== 3'd0 || alu_a !== 4'd0 || alu_b !== 4'd0 || alu_op !== 4'd0 ||
        result_q !== 4'd0 || flags_q !== 4'd0 || done !== 1'b0) begin
      fails++;
      $display("FAIL clear_prio got st=%0d a=%0d b=%0d op=%0d r=%0d f=%0d d=%0d want all 0",
               state_o, alu_a, alu_b, alu_op, result_q, flags_q, done);
    end
  endtask

  task automatic test_async_reset;
    int n;
    press_next(4'd6);
    press_next(4'd7);
    sw = 4'd2;
    btn_next = 1'b1;
    n = 0;
    while (state_o !== 3'd3 && n < 10) begin
      tick(1);
      n++;
    end
    tests++;
    if (state_o !== 3'd3) begin
      fails++;
      $display("FAIL arst_reach_exec got st=%0d want 3", state_o);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (state_o !== 3'd0 || alu_a !== 4'd0 || alu_b !== 4'd0 || alu_op !== 4'd0 ||
        result_q !== 4'd0 || done !== 1'b0 || disp_right !== 4'd0) begin
      fails++;
      $display("FAIL arst_immediate got st=%0d a=%0d b=%0d op=%0d r=%0d d=%0d R=%0d want all 0",
               state_o, alu_a, alu_b, alu_op, result_q, done, disp_right);
    end
    btn_next = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(6);
    tests++;
    if (state_o !== 3'd0) begin
      fails++;
      $display("FAIL arst_no_stale got st=%0d want 0", state_o);
    end
  endtask

  task automatic test_timeout;
    int n;
    sw = 4'd11;
    btn_next = 1'b1;
    n = 0;
    while (state_o !== 3'd1 && n < 10) begin
      tick(1);
      n++;
    end
    btn_next = 1'b0;
    tests++;
    if (state_o !== 3'd1 || alu_a !== 4'd11) begin
      fails++;
      $display("FAIL to_enter got st=%0d a=%0d want st=1 a=11", state_o, alu_a);
    end
`ifdef ALU_SEQ_TIMEOUT_EN
    tick(15);
    tests++;
    if (state_o !== 3'd1) begin
      fails++;
      $display("FAIL to_before got st=%0d want 1", state_o);
    end
    tick(1);
    tests++;
    if (state_o !== 3'd0 || alu_a !== 4'd0) begin
      fails++;
      $display("FAIL to_fire got st=%0d a=%0d want st=0 a=0", state_o, alu_a);
    end
`else
    tick(1000);
    tests++;
    if (state_o !== 3'd1 || alu_a !== 4'd11) begin
      fails++;
      $display("FAIL to_none got st=%0d a=%0d want st=1 a=11", state_o, alu_a);
    end
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(1);
    test_reset();
    test_basic();
    test_back_to_back();
    test_hold_latency();
    test_clear();
    test_async_reset();
    test_timeout();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
